alu181_arbiter: RTL
===================

// Module: alu181_arbiter
// PURPOSE
//   Shares one 8-bit ALU181 datapath (A, B, Sel[5:0] -> F) between NREQ requesters.
//   Each requester submits {A, B, Sel} over a valid/ready handshake.
//   The arbiter grants round-robin, drives the ALU from registered operands, and
//   captures F. It then returns F with the requester ID over a valid/ready response.
//   Sits between the operand sources and the ALU181 instance; the ALU itself is external.
// PARAMETERS
//   WIDTH  8  operand/result width (A, B, F)
//   SELW   6  ALU function-select width (Sel)
//   NREQ   2  number of requesters; 2..8
//   IDW    1  requester-ID width; NREQ <= 2**IDW required
// PORTS
//   clk        in   1          single clock, rising edge
//   rst        in   1          asynchronous, active-high reset
//   req_valid  in   NREQ       requester i has an operation pending
//   req_ready  out  NREQ       one-hot accept; op i is taken when req_valid[i] & req_ready[i]
//   req_a      in   NREQ*WIDTH operand A; requester i occupies slice [i*WIDTH +: WIDTH]
//   req_b      in   NREQ*WIDTH operand B; same slicing
//   req_sel    in   NREQ*SELW  ALU select; slice [i*SELW +: SELW]
//   alu_a      out  WIDTH      to ALU181 A (registered)
//   alu_b      out  WIDTH      to ALU181 B (registered)
//   alu_sel    out  SELW       to ALU181 Sel (registered)
//   alu_f      in   WIDTH      from ALU181 F (combinational result)
//   rsp_valid  out  1          result available
//   rsp_ready  in   1          consumer accepts result
//   rsp_data   out  WIDTH      captured F
//   rsp_id     out  IDW        index of the requester that owns rsp_data
//   busy       out  1          high in every state except IDLE
// BEHAVIOUR
//   Reset (async, immediate):
//   - state=IDLE; alu_a=0, alu_b=0, alu_sel=0.
//   - rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
//   - last_grant=NREQ-1, so requester 0 wins first.
//   - An in-flight operation is discarded. No response is issued for it.
//   FSM (one op in flight max): IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
//   IDLE:
//   - Grant goes to the first i with req_valid[i], searching from last_grant+1 mod NREQ upward.
//   - req_ready = onehot(grant) combinationally, only in IDLE and only if any req_valid.
//   - req_ready is 0 in all other states. There is no combinational path from rsp_ready.
//   - On accept: latch req_a/b/sel[grant] into alu_a/b/sel; latch id; last_grant=grant; go ISSUE.
//   - No valid request: stay in IDLE; alu_* hold their last values.
//   ISSUE: alu_* stable (ALU settle cycle) -> CAPTURE.
//   CAPTURE: rsp_data<=alu_f, rsp_id<=id, rsp_valid<=1 -> RESP.
//   RESP:
//   - rsp_valid, rsp_data and rsp_id hold steady until rsp_ready.
//   - On rsp_valid & rsp_ready: rsp_valid<=0 -> IDLE.
//   Latency and throughput:
//   - Accept at edge T; rsp_valid is high after edge T+2.
//   - Minimum 4 cycles per operation when rsp_ready is held at 1.
//   Requester rules:
//   - Once req_valid is raised, it holds with stable data until accepted.
//   - Dropping req_valid early is legal; the request is simply not granted.
//   Fairness: a requester waits at most NREQ-1 grants while continuously valid.
//   Simultaneous events:
//   - A new request arriving during ISSUE, CAPTURE or RESP waits; it is never lost.
//   - The rsp handshake and new requests never overlap, because IDLE is re-entered first.
//   alu_f is sampled only in CAPTURE. Changes on alu_f in other states are ignored.
// TESTING
//   Bench ALU stub: F = A ^ B.
//   1 Single op: req0 A=8'h85 B=8'hAA Sel=6'b001111, rsp_ready=1 ->
//     req_ready[0] in the accept cycle; alu_sel=6'b001111;
//     rsp_data=8'h2F, rsp_id=0, 3 cycles after accept.
//   2 Contention: req0 and req1 both valid from reset, rsp_ready=1 ->
//     grants go 0,1,0,1; each requester waits at most one op.
//   3 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid ->
//     rsp_data and rsp_id stable; req_ready stays 0; busy=1.
//     Raising rsp_ready completes the handshake and returns to IDLE in 1 cycle.
//   4 Reset mid-op: assert rst in CAPTURE ->
//     all outputs at reset values immediately; no response issued.
//     The next op goes to requester 0.
//   5 Sel sweep: req1 issues Sel=6'b000001, 6'b001011, 6'b101011, 6'b101000 in turn ->
//     alu_sel matches each value during its ISSUE/CAPTURE cycles; rsp_id=1 each time.
//   6 Operand isolation: req0 changes req_a after accept ->
//     alu_a and rsp_data reflect the latched value only.

Source files
------------

// File: rtl/alu181_arbiter.sv
// alu181_arbiter: round-robin sharing of one external ALU181 datapath between
// NREQ requesters. One operation in flight: IDLE -> ISSUE -> CAPTURE -> RESP.
module alu181_arbiter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SELW  = 6,
   parameter int unsigned NREQ  = 2,
   parameter int unsigned IDW   = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*WIDTH-1:0]  req_a,
   input  logic [NREQ*WIDTH-1:0]  req_b,
   input  logic [NREQ*SELW-1:0]   req_sel,
   output logic [WIDTH-1:0]       alu_a,
   output logic [WIDTH-1:0]       alu_b,
   output logic [SELW-1:0]        alu_sel,
   input  logic [WIDTH-1:0]       alu_f,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [WIDTH-1:0]       rsp_data,
   output logic [IDW-1:0]         rsp_id,
   output logic                   busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t             state_q;
   logic [IDW-1:0]     last_grant_q;
   logic [IDW-1:0]     id_q;
   logic [WIDTH-1:0]   alu_a_q;
   logic [WIDTH-1:0]   alu_b_q;
   logic [SELW-1:0]    alu_sel_q;
   logic               rsp_valid_q;
   logic [WIDTH-1:0]   rsp_data_q;
   logic [IDW-1:0]     rsp_id_q;

   logic               grant_vld;
   logic [IDW-1:0]     grant_idx;
   logic               hi_vld;
   logic [IDW-1:0]     hi_idx;
   logic [IDW-1:0]     lo_idx;
   logic [WIDTH-1:0]   a_sel;
   logic [WIDTH-1:0]   b_sel;
   logic [SELW-1:0]    s_sel;

   // Round-robin pick: lowest valid index above last_grant, else lowest valid index overall.
   always_comb begin
      grant_vld = 1'b0;
      hi_vld    = 1'b0;
      hi_idx    = '0;
      lo_idx    = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            grant_vld = 1'b1;
            lo_idx    = IDW'(i);
            if (IDW'(i) > last_grant_q) begin
               hi_vld = 1'b1;
               hi_idx = IDW'(i);
            end
         end
      end
      grant_idx = hi_vld ? hi_idx : lo_idx;
   end

   // Operand mux for the granted requester, plus the one-hot accept (IDLE only).
   always_comb begin
      a_sel     = '0;
      b_sel     = '0;
      s_sel     = '0;
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == IDW'(i)) begin
            a_sel        = req_a[i*WIDTH +: WIDTH];
            b_sel        = req_b[i*WIDTH +: WIDTH];
            s_sel        = req_sel[i*SELW +: SELW];
            req_ready[i] = (state_q == IDLE) && grant_vld;
         end
      end
   end

   // Operation sequencer: latch operands, let the ALU settle, capture F, hold response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= IDW'(NREQ - 1);
         id_q         <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_sel_q    <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_id_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_vld) begin
                  alu_a_q      <= a_sel;
                  alu_b_q      <= b_sel;
                  alu_sel_q    <= s_sel;
                  id_q         <= grant_idx;
                  last_grant_q <= grant_idx;
                  state_q      <= ISSUE;
               end
            end
            ISSUE: begin
               state_q <= CAPTURE;
            end
            CAPTURE: begin
               rsp_data_q  <= alu_f;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_sel   = alu_sel_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = (state_q != IDLE);

endmodule
